// File: rtl/sobel_kernel.sv
// Streaming 3x3 Sobel stage: two line buffers, a sliding window and a
// three-stage arithmetic pipeline producing signed Gx/Gy per input pixel.
module sobel_kernel #(
    parameter int DATA_WIDTH          = 8,
    parameter int GRADIENT_DATA_WIDTH = 12,
    parameter int IMG_WIDTH           = 640,
    parameter int IMG_HEIGHT          = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_sof,
    output logic                           out_valid,
    output logic [GRADIENT_DATA_WIDTH-1:0] Gx,
    output logic [GRADIENT_DATA_WIDTH-1:0] Gy,
    output logic                           out_sof,
    output logic                           out_eol
);

    localparam int DW = DATA_WIDTH;
    localparam int GW = GRADIENT_DATA_WIDTH;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef logic [DW-1:0]        pix_t;
    typedef logic signed [GW-1:0] grad_t;

    function automatic grad_t ext(input pix_t p);
        return grad_t'(p);
    endfunction

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row-1, lb0 holds row-2 (never cleared)
    // ------------------------------------------------------------------
    pix_t lb0_q [IMG_WIDTH];
    pix_t lb1_q [IMG_WIDTH];
    pix_t lb0_rd;
    pix_t lb1_rd;

    assign lb0_rd = lb0_q[cur_col];
    assign lb1_rd = lb1_q[cur_col];

    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb1_q[cur_col] <= in_data;
            lb0_q[cur_col] <= lb1_rd;
        end
    end

    // ------------------------------------------------------------------
    // Window (row 0 oldest, column 2 newest) and stage-1 sideband
    // ------------------------------------------------------------------
    pix_t win_q [3][3];
    pix_t win_d [3][3];
    logic v1_q, v1_d;
    logic sof1_q, sof1_d;
    logic eol1_q, eol1_d;
    logic zero1_q, zero1_d;

    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = in_data;
        end
    end

    always_comb begin
        v1_d    = in_valid;
        sof1_d  = in_valid & in_sof;
        eol1_d  = in_valid & (cur_col == COL_LAST);
        zero1_d = (int'(cur_row) < 2) || (int'(cur_col) < 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            zero1_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            v1_q    <= v1_d;
            sof1_q  <= sof1_d;
            eol1_q  <= eol1_d;
            zero1_q <= zero1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: weighted edge sums of the window
    // ------------------------------------------------------------------
    grad_t gxp_q, gxp_d;
    grad_t gxn_q, gxn_d;
    grad_t gyp_q, gyp_d;
    grad_t gyn_q, gyn_d;
    logic  v2_q, sof2_q, eol2_q, zero2_q;

    always_comb begin
        gxp_d = ext(win_q[0][2]) + (ext(win_q[1][2]) << 1) + ext(win_q[2][2]);
        gxn_d = ext(win_q[0][0]) + (ext(win_q[1][0]) << 1) + ext(win_q[2][0]);
        gyp_d = ext(win_q[2][0]) + (ext(win_q[2][1]) << 1) + ext(win_q[2][2]);
        gyn_d = ext(win_q[0][0]) + (ext(win_q[0][1]) << 1) + ext(win_q[0][2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gxp_q   <= '0;
            gxn_q   <= '0;
            gyp_q   <= '0;
            gyn_q   <= '0;
            v2_q    <= 1'b0;
            sof2_q  <= 1'b0;
            eol2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else begin
            gxp_q   <= gxp_d;
            gxn_q   <= gxn_d;
            gyp_q   <= gyp_d;
            gyn_q   <= gyn_d;
            v2_q    <= v1_q;
            sof2_q  <= sof1_q;
            eol2_q  <= eol1_q;
            zero2_q <= zero1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: differences, border forced to zero
    // ------------------------------------------------------------------
    grad_t gx_q, gx_d;
    grad_t gy_q, gy_d;
    logic  ov_q, osof_q, oeol_q;

    always_comb begin
        gx_d = zero2_q ? '0 : gxp_q - gxn_q;
        gy_d = zero2_q ? '0 : gyp_q - gyn_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            ov_q   <= 1'b0;
            osof_q <= 1'b0;
            oeol_q <= 1'b0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            ov_q   <= v2_q;
            osof_q <= sof2_q;
            oeol_q <= eol2_q;
        end
    end

    assign out_valid = ov_q;
    assign Gx        = gx_q;
    assign Gy        = gy_q;
    assign out_sof   = osof_q;
    assign out_eol   = oeol_q;

endmodule

// File: tb/tb_sobel_kernel.sv
// Randomized bench for sobel_kernel on an 8x6 image against a per-cycle
// convolution reference model.
module tb_sobel_kernel;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NS = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic [11:0] Gx;
    logic [11:0] Gy;
    logic        out_sof;
    logic        out_eol;

    sobel_kernel #(
        .DATA_WIDTH(8),
        .GRADIENT_DATA_WIDTH(12),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
        .out_valid(out_valid),
        .Gx(Gx),
        .Gy(Gy),
        .out_sof(out_sof),
        .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Expected output per cycle slot
    bit ev [NS];
    bit ez [NS];
    bit es [NS];
    bit ee [NS];
    int egx [NS];
    int egy [NS];

    int mr = 0;
    int mc = 0;
    int img [H][W];

    task automatic model_pixel(input int n, input int d, input bit s);
        int r, c, gx, gy, p, wx, wy;
        r = s ? 0 : mr;
        c = s ? 0 : mc;
        img[r][c] = d;
        gx = 0;
        gy = 0;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    p  = img[r-2+i][c-2+j];
                    wx = (j == 0 ? -1 : (j == 2 ? 1 : 0)) * (i == 1 ? 2 : 1);
                    wy = (i == 0 ? -1 : (i == 2 ? 1 : 0)) * (j == 1 ? 2 : 1);
                    gx += wx * p;
                    gy += wy * p;
                end
            end
        end
        ev[n+3]  = 1'b1;
        egx[n+3] = gx;
        egy[n+3] = gy;
        es[n+3]  = s;
        ee[n+3]  = (c == W - 1);
        c++;
        if (c == W) begin
            c = 0;
            r = (r == H - 1) ? 0 : r + 1;
        end
        mr = r;
        mc = c;
    endtask

    task automatic step(input bit v, input int d, input bit s, input bit r);
        int n;
        n = cyc;
        if (n + 4 >= NS) begin
            n_bad++;
            $display("FAIL cycle_budget: got %0d expected < %0d", n, NS - 4);
            $fatal(1, "cycle budget exhausted");
        end
        rst      = r;
        in_valid = v;
        in_data  = d[7:0];
        in_sof   = s;
        if (r) begin
            for (int k = 1; k <= 3; k++) begin
                ev[n+k] = 1'b0;
                es[n+k] = 1'b0;
                ee[n+k] = 1'b0;
            end
            ez[n+1] = 1'b1;
            mr = 0;
            mc = 0;
        end else if (v) begin
            model_pixel(n, d & 255, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return (c >= 4) ? 255 : 0;
            2: return (r <= 2) ? 255 : 0;
            3: return 10 * c;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic gap(input int pct);
        while (int'($urandom_range(0, 99)) < pct)
            step(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_pixels(input int kind, input int pct, input bit use_sof,
                               input int npix);
        int r, c;
        for (int k = 0; k < npix; k++) begin
            r = (k / W) % H;
            c = k % W;
            gap(pct);
            step(1'b1, pix(kind, r, c), use_sof && k == 0, 1'b0);
        end
    endtask

    // Observed outputs indexed by position within the frame
    int          oidx = 0;
    int          obs_gx [64];
    int          obs_gy [64];
    logic [11:0] obs_raw_gy [64];

    always @(negedge clk) begin
        if (cyc >= 1 && !done) begin
            chk("out_valid", int'(out_valid), int'(ev[cyc]));
            if (ev[cyc]) begin
                chk("gx", $signed(Gx), egx[cyc]);
                chk("gy", $signed(Gy), egy[cyc]);
                chk("out_sof", int'(out_sof), int'(es[cyc]));
                chk("out_eol", int'(out_eol), int'(ee[cyc]));
            end
            if (ez[cyc]) begin
                chk("rst_gx", int'(Gx), 0);
                chk("rst_gy", int'(Gy), 0);
                chk("rst_sof", int'(out_sof), 0);
                chk("rst_eol", int'(out_eol), 0);
            end
            if (out_valid) begin
                if (out_sof) oidx = 0;
                if (oidx < 64) begin
                    obs_gx[oidx]     = $signed(Gx);
                    obs_gy[oidx]     = $signed(Gy);
                    obs_raw_gy[oidx] = Gy;
                end
                oidx++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Constant frame
        send_pixels(0, 0, 1'b1, W * H);
        idle(4);
        chk("const_count", oidx, W * H);

        // Vertical edge
        send_pixels(1, 0, 1'b1, W * H);
        idle(4);
        chk("vedge_gx_c4", obs_gx[2*W+4], 1020);
        chk("vedge_gx_c5", obs_gx[3*W+5], 1020);
        chk("vedge_gx_c6", obs_gx[3*W+6], 0);
        chk("vedge_gy", obs_gy[4*W+4], 0);

        // Horizontal edge
        send_pixels(2, 0, 1'b1, W * H);
        idle(4);
        chk("hedge_gy_r3", obs_gy[3*W+3], -1020);
        chk("hedge_gy_r4", obs_gy[4*W+2], -1020);
        chk("hedge_gy_r5", obs_gy[5*W+3], 0);
        chk("hedge_raw", int'(obs_raw_gy[3*W+3]), 'hC04);

        // Ramp with random gaps
        send_pixels(3, 35, 1'b1, W * H);
        idle(4);
        for (int k = 0; k < W * H; k++)
            chk("ramp_gap_gx", obs_gx[k], (k / W >= 2 && k % W >= 2) ? 80 : 0);

        // in_sof reasserted at (3,5)
        send_pixels(4, 20, 1'b1, 3 * W + 5);
        step(1'b1, int'($urandom_range(0, 255)), 1'b1, 1'b0);
        send_pixels(4, 20, 1'b0, W * H - 1);
        idle(4);

        // Reset mid-frame at row 4, then fresh frames
        send_pixels(4, 0, 1'b1, 4 * W + 3);
        step(1'b1, 55, 1'b0, 1'b1);
        step(1'b1, 77, 1'b1, 1'b1);
        send_pixels(0, 0, 1'b0, W * H);
        send_pixels(0, 0, 1'b1, W * H);
        idle(4);
        chk("post_rst_count", oidx, W * H);

        // Random frames with gaps
        for (int f = 0; f < 4; f++) send_pixels(4, 20, 1'b1, W * H);
        idle(6);

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
